// File: rtl/udp_rx_port_demux.sv
// udp_rx_port_demux: UDP receive stage with destination-port demultiplexing.
// Strips the 8-byte UDP header, matches the destination port against NUM_PORTS
// programmable entries (lowest index wins) and forwards the payload tagged with
// the matched channel. Length, upstream error and (optionally) checksum are
// checked and reported on the EoF beat. Fixed 3-cycle latency input to output.
// Optional feature: define UDP_RX_CSUM_EN to build the checksum accumulator/check.
//
// Handshake: ValIn qualifies every input beat (SoFIn/EoFIn/ErrIn/DataIn); there is
// no backpressure, a low ValIn is a stall that reappears as ValOut=0 three cycles later.
module udp_rx_port_demux #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    SoFIn,
    input  logic                    EoFIn,
    input  logic                    ValIn,
    input  logic                    ErrIn,
    input  logic [7:0]              DataIn,
    input  logic [23:0]             PHeadIn,
    input  logic [31:0]             RemoteIPIn,
    input  logic [47:0]             RemoteMACIn,
    input  logic [16*NUM_PORTS-1:0] PortTable,
    input  logic [NUM_PORTS-1:0]    PortEnable,
    output logic                    SoFOut,
    output logic                    EoFOut,
    output logic                    ValOut,
    output logic                    ErrOut,
    output logic [7:0]              DataOut,
    output logic [IDX_W-1:0]        ChanOut,
    output logic [47:0]             RemoteMACOut,
    output logic [31:0]             RemoteIPOut,
    output logic [15:0]             RemotePortOut,
    output logic [15:0]             DropCnt,
    output logic [2:0]              StateDbg
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_HIT  = 3'd2;
    localparam logic [2:0] ST_PAY  = 3'd3;
    localparam logic [2:0] ST_DROP = 3'd4;

    logic [2:0]       state, stateNext;
    logic [15:0]      byteCnt, idx;
    logic [15:0]      srcPort, lenField;
    logic [7:0]       dstHi;
    logic             errAcc, errNext, lenBad, inHdr;
    logic [IDX_W-1:0] capChan, hitIdx;
    logic [31:0]      capIp;
    logic [47:0]      capMac;
    logic             hit;
    logic             beatVal, beatSof, beatEof, beatErr, beatChk, dropInc;

    // Stage registers (s1 = after input byte, s2 = middle, outputs = s3)
    logic             s1Val, s1Sof, s1Eof, s1Err, s1Chk;
    logic [7:0]       s1Data;
    logic [IDX_W-1:0] s1Chan;
    logic [15:0]      s1Port;
    logic [31:0]      s1Ip;
    logic [47:0]      s1Mac;
    logic             s2Val, s2Sof, s2Eof, s2Err, s2Chk;
    logic [7:0]       s2Data;
    logic [IDX_W-1:0] s2Chan;
    logic [15:0]      s2Port;
    logic [31:0]      s2Ip;
    logic [47:0]      s2Mac;
    logic             csumFail;

    assign StateDbg = state;

    // Byte index of the current beat; a SoF always restarts at byte 0.
    always_comb begin
        idx     = SoFIn ? 16'd0 : byteCnt;
        inHdr   = SoFIn || (state == ST_HDR) || (state == ST_HIT);
        errNext = (SoFIn ? 1'b0 : errAcc) | ErrIn;
        lenBad  = (lenField != (idx + 16'd1));
    end

    // Destination-port lookup; scanning downward lets the lowest index win.
    always_comb begin
        hit    = 1'b0;
        hitIdx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (PortEnable[i] && (PortTable[16*i +: 16] == {dstHi, DataIn})) begin
                hit    = 1'b1;
                hitIdx = IDX_W'(i);
            end
        end
    end

    // Frame FSM decode: next state, output beat for this byte, drop event.
    always_comb begin
        stateNext = state;
        beatVal   = 1'b0;
        beatSof   = 1'b0;
        beatEof   = 1'b0;
        beatErr   = 1'b0;
        beatChk   = 1'b0;
        dropInc   = 1'b0;
        if (ValIn) begin
            // Missing EoF: close the open frame in the slot of the new SoF byte.
            if (SoFIn && (state == ST_PAY)) begin
                beatEof = 1'b1;
                beatErr = 1'b1;
            end
            if (inHdr) begin
                stateNext = SoFIn ? ST_HDR : state;
                if (idx == 16'd3) begin
                    stateNext = hit ? ST_HIT : ST_DROP;
                    dropInc   = !hit;
                end
                if ((idx == 16'd7) && (stateNext == ST_HIT)) begin
                    stateNext = ST_PAY;
                    if (EoFIn) begin
                        // Zero payload: lone SoF/EoF marker carrying the checks.
                        beatSof = 1'b1;
                        beatEof = 1'b1;
                        beatErr = errNext | lenBad;
                        beatChk = 1'b1;
                    end
                end
                if (EoFIn) begin
                    if (idx < 16'd7) dropInc = 1'b1;
                    stateNext = ST_IDLE;
                end
            end else if (state == ST_PAY) begin
                beatVal = 1'b1;
                beatSof = (idx == 16'd8);
                beatEof = EoFIn;
                beatErr = EoFIn & (errNext | lenBad);
                beatChk = EoFIn;
                if (EoFIn) stateNext = ST_IDLE;
            end else if (state == ST_DROP) begin
                if (EoFIn) stateNext = ST_IDLE;
            end
        end
    end

    // Frame state: FSM, byte counter and captured header fields.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= ST_IDLE;
            byteCnt  <= 16'd0;
            srcPort  <= 16'd0;
            dstHi    <= 8'd0;
            lenField <= 16'd0;
            errAcc   <= 1'b0;
            capChan  <= '0;
            capIp    <= 32'd0;
            capMac   <= 48'd0;
        end else if (ValIn && (SoFIn || (state != ST_IDLE))) begin
            state   <= stateNext;
            byteCnt <= idx + 16'd1;
            errAcc  <= errNext;
            if (SoFIn) begin
                capIp  <= RemoteIPIn;
                capMac <= RemoteMACIn;
            end
            if (inHdr) begin
                case (idx)
                    16'd0: srcPort[15:8]  <= DataIn;
                    16'd1: srcPort[7:0]   <= DataIn;
                    16'd2: dstHi          <= DataIn;
                    16'd3: if (hit) capChan <= hitIdx;
                    16'd4: lenField[15:8] <= DataIn;
                    16'd5: lenField[7:0]  <= DataIn;
                    default: ;
                endcase
            end
        end
    end

    // Dropped-frame counter, saturating.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)                              DropCnt <= 16'd0;
        else if (dropInc && DropCnt != 16'hFFFF) DropCnt <= DropCnt + 16'd1;
    end

`ifdef UDP_RX_CSUM_EN
    logic [31:0] acc, accNext, s1Sum;
    logic [15:0] csumField, csumNext, fold2;
    logic [7:0]  csumHi;
    logic [16:0] s2Fold;
    logic        s1CsumZero, s2CsumZero;

    // Running sum: even bytes are the high half of a word, odd bytes the low half.
    always_comb begin
        accNext  = (SoFIn ? {8'h00, PHeadIn} : acc) +
                   (idx[0] ? {24'h0, DataIn} : {16'h0, DataIn, 8'h00});
        csumNext = (idx == 16'd7) ? {csumHi, DataIn} : csumField;
        fold2    = s2Fold[15:0] + {15'd0, s2Fold[16]};
        csumFail = s2Chk && !s2CsumZero && (fold2 != 16'hFFFF);
    end

    // Checksum accumulator and received checksum field.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            acc       <= 32'd0;
            csumHi    <= 8'd0;
            csumField <= 16'd0;
        end else if (ValIn && (SoFIn || (state != ST_IDLE))) begin
            acc <= accNext;
            if (inHdr && idx == 16'd6) csumHi    <= DataIn;
            if (inHdr && idx == 16'd7) csumField <= {csumHi, DataIn};
        end
    end

    // Checksum pipeline: capture sum, fold once, final fold/compare at the output.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            s1Sum      <= 32'd0;
            s1CsumZero <= 1'b0;
            s2Fold     <= 17'd0;
            s2CsumZero <= 1'b0;
        end else begin
            s1Sum      <= accNext;
            s1CsumZero <= (csumNext == 16'h0000);
            s2Fold     <= {1'b0, s1Sum[15:0]} + {1'b0, s1Sum[31:16]};
            s2CsumZero <= s1CsumZero;
        end
    end
`else
    logic unusedPHead;
    assign unusedPHead = ^PHeadIn;
    assign csumFail    = 1'b0;
`endif

    // Three-stage output pipeline; frame metadata advances only with SoF beats.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            {s1Val, s1Sof, s1Eof, s1Err, s1Chk} <= 5'd0;
            {s2Val, s2Sof, s2Eof, s2Err, s2Chk} <= 5'd0;
            {ValOut, SoFOut, EoFOut, ErrOut}    <= 4'd0;
            s1Data <= 8'd0;  s2Data <= 8'd0;  DataOut <= 8'd0;
            s1Chan <= '0;    s2Chan <= '0;    ChanOut <= '0;
            s1Port <= 16'd0; s2Port <= 16'd0; RemotePortOut <= 16'd0;
            s1Ip   <= 32'd0; s2Ip   <= 32'd0; RemoteIPOut   <= 32'd0;
            s1Mac  <= 48'd0; s2Mac  <= 48'd0; RemoteMACOut  <= 48'd0;
        end else begin
            s1Val  <= beatVal;
            s1Sof  <= beatSof;
            s1Eof  <= beatEof;
            s1Err  <= beatErr;
            s1Chk  <= beatChk;
            s1Data <= beatVal ? DataIn : 8'h00;
            if (beatSof) begin
                s1Chan <= capChan;
                s1Port <= srcPort;
                s1Ip   <= capIp;
                s1Mac  <= capMac;
            end
            {s2Val, s2Sof, s2Eof, s2Err, s2Chk} <= {s1Val, s1Sof, s1Eof, s1Err, s1Chk};
            s2Data <= s1Data;
            if (s1Sof) begin
                s2Chan <= s1Chan;
                s2Port <= s1Port;
                s2Ip   <= s1Ip;
                s2Mac  <= s1Mac;
            end
            ValOut  <= s2Val;
            SoFOut  <= s2Sof;
            EoFOut  <= s2Eof;
            ErrOut  <= s2Err | csumFail;
            DataOut <= s2Data;
            if (s2Sof) begin
                ChanOut       <= s2Chan;
                RemotePortOut <= s2Port;
                RemoteIPOut   <= s2Ip;
                RemoteMACOut  <= s2Mac;
            end
        end
    end
endmodule

// File: tb/tb_udp_rx_port_demux.sv
// Testbench for udp_rx_port_demux: frame-level reference model feeding an
// expected-beat queue; every output beat is checked for content and timing.
module tb_udp_rx_port_demux;
    localparam int NUM_PORTS = 4;
    localparam int IDX_W     = 2;
`ifdef UDP_RX_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sof_in = 0, eof_in = 0, val_in = 0, err_in = 0;
    logic [7:0]  data_in = 0;
    logic [23:0] phead_in = 0;
    logic [31:0] ip_in = 0;
    logic [47:0] mac_in = 0;
    logic [63:0] port_table = 0;
    logic [3:0]  port_en = 0;
    logic        sof_out, eof_out, val_out, err_out;
    logic [7:0]  data_out;
    logic [1:0]  chan_out;
    logic [47:0] mac_out;
    logic [31:0] ip_out;
    logic [15:0] port_out, drop_cnt;
    logic [2:0]  state_dbg;

    udp_rx_port_demux #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) dut (
        .Clk(clk), .Rst(rst), .SoFIn(sof_in), .EoFIn(eof_in), .ValIn(val_in), .ErrIn(err_in),
        .DataIn(data_in), .PHeadIn(phead_in), .RemoteIPIn(ip_in), .RemoteMACIn(mac_in),
        .PortTable(port_table), .PortEnable(port_en),
        .SoFOut(sof_out), .EoFOut(eof_out), .ValOut(val_out), .ErrOut(err_out),
        .DataOut(data_out), .ChanOut(chan_out), .RemoteMACOut(mac_out), .RemoteIPOut(ip_out),
        .RemotePortOut(port_out), .DropCnt(drop_cnt), .StateDbg(state_dbg)
    );

    // Clock and cycle stamp
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [125:0] exp_q[$];
    logic [7:0]   seg[$];
    int           n_checks = 0;
    int           n_err = 0;
    int           exp_drop = 0;
    bit           open_frame = 0;
    logic [1:0]   last_chan = 0;
    logic [23:0]  phead;
    logic [31:0]  cur_ip;
    logic [47:0]  cur_mac;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [125:0] mk(input int c, input logic s, input logic e, input logic v,
                                        input logic r, input logic [1:0] ch, input logic [7:0] d,
                                        input logic [95:0] m);
        logic [15:0] cc;
        cc = c[15:0];
        return {cc, s, e, v, r, ch, d, m};
    endfunction

    // Output monitor: every beat with any marker must match the queue head.
    always @(negedge clk) begin
        logic [125:0] item;
        logic [15:0]  cc;
        if (!rst && (val_out || sof_out || eof_out)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {sof_out, eof_out, val_out}, 3'b000);
            end else begin
                item = exp_q.pop_front();
                cc = cyc[15:0];
                check("beat", {cc, sof_out, eof_out, val_out, err_out, chan_out, data_out,
                               (sof_out ? {port_out, ip_out, mac_out} : 96'h0)}, item);
            end
        end
    end

    // Ones-complement fold of pseudo-header seed plus all segment words.
    function automatic logic [15:0] fold_sum();
        logic [31:0] s;
        logic [16:0] f;
        s = {8'h00, phead};
        for (int i = 0; i < seg.size(); i++)
            s += (i % 2 == 0) ? {16'h0, seg[i], 8'h00} : {24'h0, seg[i]};
        f = {1'b0, s[15:0]} + {1'b0, s[31:16]};
        return f[15:0] + {15'h0, f[16]};
    endfunction

    task automatic new_meta();
        phead   = 24'($urandom);
        cur_ip  = $urandom;
        cur_mac = {16'($urandom), $urandom};
    endtask

    task automatic build_seg(input logic [15:0] sport, input logic [15:0] dport,
                             input logic [15:0] lenf, input int pay_len);
        logic [15:0] v;
        seg.delete();
        seg.push_back(sport[15:8]); seg.push_back(sport[7:0]);
        seg.push_back(dport[15:8]); seg.push_back(dport[7:0]);
        seg.push_back(lenf[15:8]);  seg.push_back(lenf[7:0]);
        seg.push_back(8'h00);       seg.push_back(8'h00);
        for (int i = 0; i < pay_len; i++) seg.push_back(8'($urandom));
        v = ~fold_sum();
        if (v == 16'h0000) v = 16'hFFFF;
        seg[6] = v[15:8];
        seg[7] = v[7:0];
    endtask

    task automatic drive_idle();
        @(posedge clk); #1;
        val_in = 0; sof_in = 0; eof_in = 0; err_in = 0; data_in = 8'($urandom);
    endtask

    task automatic drive_byte(input logic s, input logic e, input logic [7:0] d, input logic r);
        logic [63:0] junk;
        @(posedge clk); #1;
        junk = {$urandom, $urandom};
        val_in = 1; sof_in = s; eof_in = e; data_in = d; err_in = r;
        phead_in = s ? phead   : junk[23:0];
        ip_in    = s ? cur_ip  : junk[63:32];
        mac_in   = s ? cur_mac : junk[47:0];
    endtask

    // Drive the first n_drive bytes of seg (EoF only if the whole segment is sent).
    task automatic send_frame(input int n_drive, input bit gaps, input int err_at);
        int          n, c;
        bit          has_eof, hit, exp_err, csum_ok, s, e;
        logic [1:0]  chan;
        logic [15:0] dport, lenf, csf;
        logic [95:0] meta;
        n = seg.size();
        has_eof = (n_drive == n);
        dport = {seg[2], seg[3]};
        hit = 0; chan = 0;
        for (int i = NUM_PORTS - 1; i >= 0; i--)
            if (port_en[i] && port_table[16*i +: 16] == dport) begin hit = 1; chan = i[1:0]; end
        lenf = (n > 5) ? {seg[4], seg[5]} : 16'h0;
        csf  = (n > 7) ? {seg[6], seg[7]} : 16'h0;
        csum_ok = (fold_sum() == 16'hFFFF);
        exp_err = (err_at >= 0 && err_at < n_drive) || (lenf != n[15:0]) ||
                  (CSUM_EN && csf != 16'h0 && !csum_ok);
        meta = {seg[0], seg[1], cur_ip, cur_mac};
        if ((has_eof && n <= 7) || (n_drive >= 4 && !hit)) exp_drop++;
        for (int i = 0; i < n_drive; i++) begin
            while (gaps && $urandom_range(0, 1) == 1) drive_idle();
            e = has_eof && (i == n - 1);
            drive_byte(i == 0, e, seg[i], i == err_at);
            c = cyc;
            if (i == 0 && open_frame) begin
                exp_q.push_back(mk(c + 3, 0, 1, 0, 1, last_chan, 8'h00, 96'h0));
                open_frame = 0;
            end
            if (hit && i == 7 && has_eof && n == 8) begin
                exp_q.push_back(mk(c + 3, 1, 1, 0, exp_err, chan, 8'h00, meta));
                last_chan = chan;
            end
            if (hit && i >= 8) begin
                s = (i == 8);
                exp_q.push_back(mk(c + 3, s, e, 1, e && exp_err, chan, seg[i], s ? meta : 96'h0));
                if (s) last_chan = chan;
            end
        end
        drive_idle();
        if (hit && !has_eof && n_drive >= 8) open_frame = 1;
    endtask

    task automatic drain(input string tag);
        repeat (6) drive_idle();
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_dropcnt"}, drop_cnt, exp_drop[15:0]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Main sequence
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {sof_out, eof_out, val_out, err_out, chan_out, data_out,
                              mac_out, ip_out, port_out, drop_cnt}, 0);
        check("rst_state", state_dbg, 3'd0);
        rst = 0;
        // Stray bytes before any SoF are ignored
        for (int i = 0; i < 3; i++) drive_byte(0, i == 2, 8'hA5, 0);
        drain("stray");

        // Entry 2 holds 0x1234: 12-byte payload on channel 2
        port_table = {16'h1111, 16'h1234, 16'h2222, 16'h3333};
        port_en = 4'hF;
        new_meta(); build_seg(16'hABCD, 16'h1234, 16'd20, 12); send_frame(20, 0, -1);
        drain("basic");

        // Duplicate entries: lowest enabled index wins
        port_table = {16'h0400, 16'h1234, 16'h2222, 16'h0400};
        new_meta(); build_seg(16'h0101, 16'h0400, 16'd20, 12); send_frame(20, 0, -1);
        drain("prio0");
        port_en = 4'hE;
        new_meta(); build_seg(16'h0202, 16'h0400, 16'd20, 12); send_frame(20, 0, -1);
        drain("prio3");

        // No match, then runt
        port_table = {16'h1111, 16'h1234, 16'h2222, 16'h3333};
        port_en = 4'hF;
        new_meta(); build_seg(16'h0303, 16'h9999, 16'd20, 12); send_frame(20, 0, -1);
        drain("nomatch");
        new_meta(); build_seg(16'h0404, 16'h1234, 16'd20, 12);
        while (seg.size() > 5) void'(seg.pop_back());
        send_frame(5, 0, -1);
        drain("runt");

        // Length field disagreeing with the byte count
        new_meta(); build_seg(16'h0505, 16'h1234, 16'd24, 12); send_frame(20, 0, -1);
        drain("len_bad");

        // Corrupted payload with checksum present, then with checksum disabled
        new_meta(); build_seg(16'h0606, 16'h2222, 16'd20, 12);
        seg[12] = seg[12] ^ 8'h01;
        send_frame(20, 0, -1);
        drain("csum_bad");
        seg[6] = 8'h00; seg[7] = 8'h00;
        send_frame(20, 0, -1);
        drain("csum_off");

        // Upstream error on a header byte; odd-length payload
        new_meta(); build_seg(16'h0707, 16'h3333, 16'd20, 12); send_frame(20, 0, 2);
        drain("err_in");
        new_meta(); build_seg(16'h0808, 16'h1111, 16'd21, 13); send_frame(21, 0, -1);
        drain("odd_len");

        // Random stalls
        for (int k = 0; k < 3; k++) begin
            new_meta(); build_seg(16'h0909, 16'h1234, 16'd20, 12); send_frame(20, 1, -1);
            drain("gaps");
        end

        // Zero payload
        new_meta(); build_seg(16'h0A0A, 16'h1234, 16'd8, 0); send_frame(8, 0, -1);
        drain("zero_pay");

        // SoF inside payload closes the open frame, new frame runs normally
        new_meta(); build_seg(16'h0B0B, 16'h2222, 16'd20, 12); send_frame(14, 0, -1);
        new_meta(); build_seg(16'h0C0C, 16'h1234, 16'd20, 12); send_frame(20, 0, -1);
        drain("sof_in_pay");

        // Reset in the middle of a payload
        new_meta(); build_seg(16'h0D0D, 16'h3333, 16'd20, 12); send_frame(14, 0, -1);
        rst = 1;
        #1;
        check("rst_mid_outputs", {sof_out, eof_out, val_out, err_out, chan_out, data_out,
                                  mac_out, ip_out, port_out, drop_cnt}, 0);
        check("rst_mid_state", state_dbg, 3'd0);
        exp_q.delete();
        open_frame = 0;
        exp_drop = 0;
        @(posedge clk); #1;
        rst = 0;
        new_meta(); build_seg(16'h0E0E, 16'h1234, 16'd20, 12); send_frame(20, 0, -1);
        drain("after_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
